// File: rtl/match_pkg.sv
// Shared definitions for the match command sequencer.
// Holds the ALU opcode constants and the sequencer FSM state encoding.
// Imported by match_cmd_sequencer and match_alu_core.
package match_pkg;

  localparam int unsigned OP_INC = 17;
  localparam int unsigned OP_ADD = 21;
  localparam int unsigned OP_SUB = 34;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/match_cmd_sequencer_alu.sv
// match_alu_core: combinational opcode-match ALU.
// The first operand doubles as the opcode. All results are modulo 2^WIDTH.
//   A=OP_INC -> A+1, A=OP_ADD -> A+B, A=OP_SUB -> A-B, otherwise low bits of A*B.
// Ports:
//   A    in  WIDTH  opcode / first operand
//   B    in  WIDTH  second operand
//   XOUT out WIDTH  result
module match_alu_core
  import match_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] XOUT
);

  localparam logic [WIDTH-1:0] INC_CODE = WIDTH'(OP_INC);
  localparam logic [WIDTH-1:0] ADD_CODE = WIDTH'(OP_ADD);
  localparam logic [WIDTH-1:0] SUB_CODE = WIDTH'(OP_SUB);

  always_comb begin
    XOUT = A * B;
    if (A == INC_CODE) begin
      XOUT = A + WIDTH'(1);
    end else if (A == ADD_CODE) begin
      XOUT = A + B;
    end else if (A == SUB_CODE) begin
      XOUT = A - B;
    end
  end

endmodule

// File: rtl/match_cmd_sequencer.sv
// match_cmd_sequencer: queues (A,B) commands in a DEPTH-entry FIFO, runs each
// through the opcode-match ALU one at a time and presents the registered
// result with a valid/ready handshake.
// Optional feature: define MATCH_CMD_SEQUENCER_COUNT_EN to add the 16-bit
// CMD_COUNT output counting completed (consumed) results.
// Ports:
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   IN_VALID   in   command offered
//   IN_READY   out  FIFO not full
//   IN_A       in   opcode / first operand
//   IN_B       in   second operand
//   OUT_VALID  out  RES_DATA holds an unconsumed result
//   OUT_READY  in   consumer accepts the result
//   RES_DATA   out  registered result
//   CMD_COUNT  out  completed-command count (MATCH_CMD_SEQUENCER_COUNT_EN only)
module match_cmd_sequencer
  import match_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RES_DATA
`ifdef MATCH_CMD_SEQUENCER_COUNT_EN
  ,
  output logic [15:0]      CMD_COUNT
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] alu_out;

  state_t state;
  state_t state_nxt;
  logic   push;
  logic   pop;
  logic   capture;
  logic   empty;
  logic   out_valid_nxt;

  assign empty    = (count == '0);
  assign IN_READY = (count != (PW+1)'(DEPTH));
  assign push     = IN_VALID && IN_READY;

  match_alu_core #(.WIDTH(WIDTH)) u_alu (
    .A    (a_reg),
    .B    (b_reg),
    .XOUT (alu_out)
  );

  // Sequencer control. OUT_VALID is dropped whenever HOLD is left so that a
  // result is never presented while the next one is still being captured.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    capture       = 1'b0;
    out_valid_nxt = OUT_VALID;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        capture       = 1'b1;
        out_valid_nxt = 1'b1;
        state_nxt     = HOLD;
      end
      HOLD: begin
        if (OUT_READY) begin
          out_valid_nxt = 1'b0;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = DRIVE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a[wr_ptr] <= IN_A;
      mem_b[wr_ptr] <= IN_B;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_reg     <= '0;
      b_reg     <= '0;
      RES_DATA  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      if (pop) begin
        a_reg <= mem_a[rd_ptr];
        b_reg <= mem_b[rd_ptr];
      end
      if (capture) RES_DATA <= alu_out;
      OUT_VALID <= out_valid_nxt;
    end
  end

`ifdef MATCH_CMD_SEQUENCER_COUNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CMD_COUNT <= '0;
    end else if (OUT_VALID && OUT_READY) begin
      CMD_COUNT <= CMD_COUNT + 16'd1;
    end
  end
`endif

endmodule
